line_fit: RTL

Per-frame line-fit accumulator that sits directly upstream of the perpendicular-slope stage. It accumulates the coordinates of every masked pixel in a frame. On the end-of-frame strobe it computes the centre of mass (x_com, y_com), the least-squares slope m, and the intercept b. It then presents them with a one-cycle valid pulse in the sign-magnitude 16.8 slope format that the downstream stage consumes.

---
 rtl/line_fit_pkg.sv | 41 ++++
 rtl/line_fit_divider.sv | 77 +++++++
 rtl/line_fit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fit_pkg.sv
// Shared definitions for the line_fit accumulator: accumulator widths,
// FSM state encoding, slope fixed-point format and the intercept saturator.
package line_fit_pkg;

  // Accumulator widths (unsigned)
  localparam int N_W   = 20;
  localparam int SX_W  = 31;
  localparam int SY_W  = 30;
  localparam int SXX_W = 42;
  localparam int SXY_W = 41;

  // Width of N*Sxy, Sx*Sy, N*Sxx, Sx^2 and their differences (one spare bit for sign)
  localparam int PROD_W = 62;

  // Slope format: sign-magnitude, magnitude in 16.8 fixed point
  localparam int          SLOPE_FRAC_BITS = 8;
  localparam logic [23:0] SLOPE_MAG_MAX   = 24'hFF_FFFF;

  localparam int B_W = 18;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_DIV_X,
    ST_DIV_Y,
    ST_PRODUCTS,
    ST_DIV_M,
    ST_INTERCEPT,
    ST_DONE
  } line_fit_state_t;

  // Clamp a wide signed intercept into the 18-bit signed output range
  function automatic logic [B_W-1:0] sat_b(input logic signed [39:0] v);
    if (v > 40'sd131071)
      return 18'h1FFFF;
    else if (v < -40'sd131072)
      return 18'h20000;
    else
      return v[B_W-1:0];
  endfunction

endpackage

// File: rtl/line_fit_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. A start strobe
// while idle loads the operands; valid_out pulses for one cycle once the
// quotient is ready (WIDTH cycles later). A zero divisor completes on the
// next cycle with error_out set. Start is ignored while a divide runs.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic             valid_out,
  output logic             error_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CNT_W-1:0] count_reg;
  logic             busy_reg;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;

  // Trial subtraction for the current quotient bit; modulo-WIDTH subtract is
  // exact whenever the trial fits because the result is below the divisor.
  always_comb begin
    rem_shift = {rem_reg, quot_reg[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, divisor_reg});
    rem_sub   = rem_shift[WIDTH-1:0] - divisor_reg;
  end

  // Operand load, iteration and completion pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quot_reg    <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      valid_out   <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (busy_reg) begin
        rem_reg   <= fits ? rem_sub : rem_shift[WIDTH-1:0];
        quot_reg  <= {quot_reg[WIDTH-2:0], fits};
        count_reg <= count_reg - 1'b1;
        if (count_reg == CNT_W'(1)) begin
          busy_reg  <= 1'b0;
          valid_out <= 1'b1;
        end
      end else if (start_in) begin
        if (divisor_in == '0) begin
          quot_reg  <= '0;
          error_out <= 1'b1;
          valid_out <= 1'b1;
        end else begin
          quot_reg    <= dividend_in;
          rem_reg     <= '0;
          divisor_reg <= divisor_in;
          count_reg   <= CNT_W'(WIDTH);
          error_out   <= 1'b0;
          busy_reg    <= 1'b1;
        end
      end
    end
  end

  assign quotient_out = quot_reg;

endmodule

// File: rtl/line_fit.sv
// Per-frame least-squares line fit over masked pixels. Sums are snapshotted
// on the end-of-frame strobe, then centre of mass, slope (sign-magnitude
// 16.8) and intercept are derived using one shared sequential divider.
// Optional feature macro: LINE_FIT_INTERCEPT_EN (adds the INTERCEPT state
// and drives b_out; without it b_out is 0 and DIV_M goes straight to DONE).
module line_fit
  import line_fit_pkg::*;
#(
  parameter int DIV_WIDTH = 72
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        tabulate_in,
  output logic [10:0] x_com,
  output logic [9:0]  y_com,
  output logic [24:0] m_out,
  output logic [17:0] b_out,
  output logic        degenerate_out,
  output logic        valid_out
);

`ifdef LINE_FIT_INTERCEPT_EN
  localparam line_fit_state_t AFTER_M = ST_INTERCEPT;
`else
  localparam line_fit_state_t AFTER_M = ST_DONE;
`endif

  line_fit_state_t state_reg, state_next;

  // Running sums and their frame snapshot
  logic [N_W-1:0]   n_reg,   n_add,   n_snap;
  logic [SX_W-1:0]  sx_reg,  sx_add,  sx_snap;
  logic [SY_W-1:0]  sy_reg,  sy_add,  sy_snap;
  logic [SXX_W-1:0] sxx_reg, sxx_add, sxx_snap;
  logic [SXY_W-1:0] sxy_reg, sxy_add, sxy_snap;

  // Slope numerator (two's complement) and denominator
  logic [PROD_W-1:0] p_nsxy, p_sxsy, p_nsxx, p_sxsx;
  logic [PROD_W-1:0] num_comb, den_comb, num_reg, den_reg, num_mag;

  // Results being built for the current frame
  logic [10:0] x_work;
  logic [9:0]  y_work;
  logic [23:0] mag_work;
  logic        sign_work;
  logic        deg_work;
  logic        m_issued_reg;

  // Divider interface
  logic                 div_start_reg;
  logic [DIV_WIDTH-1:0] div_dividend_reg, div_divisor_reg, div_quotient;
  logic                 div_valid, div_error;

  divider #(.WIDTH(DIV_WIDTH)) u_divider (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (div_start_reg),
    .dividend_in  (div_dividend_reg),
    .divisor_in   (div_divisor_reg),
    .quotient_out (div_quotient),
    .valid_out    (div_valid),
    .error_out    (div_error)
  );

  // Sums including the pixel presented this cycle (also what a snapshot captures)
  always_comb begin
    n_add   = n_reg   + (valid_in ? N_W'(1) : '0);
    sx_add  = sx_reg  + (valid_in ? SX_W'(x_in) : '0);
    sy_add  = sy_reg  + (valid_in ? SY_W'(y_in) : '0);
    sxx_add = sxx_reg + (valid_in ? SXX_W'(x_in) * SXX_W'(x_in) : '0);
    sxy_add = sxy_reg + (valid_in ? SXY_W'(x_in) * SXY_W'(y_in) : '0);
  end

  // Slope products from the snapshot; num may go negative, den never does
  always_comb begin
    p_nsxy   = PROD_W'(n_snap)  * PROD_W'(sxy_snap);
    p_sxsy   = PROD_W'(sx_snap) * PROD_W'(sy_snap);
    p_nsxx   = PROD_W'(n_snap)  * PROD_W'(sxx_snap);
    p_sxsx   = PROD_W'(sx_snap) * PROD_W'(sx_snap);
    num_comb = p_nsxy - p_sxsy;
    den_comb = p_nsxx - p_sxsx;
    num_mag  = num_reg[PROD_W-1] ? (~num_reg + 1'b1) : num_reg;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_reg <= ST_ACCUM;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACCUM:     if (tabulate_in) state_next = (n_add == '0) ? ST_DONE : ST_DIV_X;
      ST_DIV_X:     if (div_valid) state_next = ST_DIV_Y;
      ST_DIV_Y:     if (div_valid) state_next = ST_PRODUCTS;
      ST_PRODUCTS:  state_next = ST_DIV_M;
      ST_DIV_M: begin
        if (!m_issued_reg) begin
          if (den_reg == '0) state_next = AFTER_M;
        end else if (div_valid) begin
          state_next = AFTER_M;
        end
      end
      ST_INTERCEPT: state_next = ST_DONE;
      ST_DONE:      state_next = ST_ACCUM;
      default:      state_next = ST_ACCUM;
    endcase
  end

  // Accumulation, snapshot, divider sequencing and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      n_reg <= '0; sx_reg <= '0; sy_reg <= '0; sxx_reg <= '0; sxy_reg <= '0;
      n_snap <= '0; sx_snap <= '0; sy_snap <= '0; sxx_snap <= '0; sxy_snap <= '0;
      num_reg          <= '0;
      den_reg          <= '0;
      x_work           <= '0;
      y_work           <= '0;
      mag_work         <= '0;
      sign_work        <= 1'b0;
      deg_work         <= 1'b0;
      m_issued_reg     <= 1'b0;
      div_start_reg    <= 1'b0;
      div_dividend_reg <= '0;
      div_divisor_reg  <= '0;
      x_com            <= '0;
      y_com            <= '0;
      m_out            <= '0;
      degenerate_out   <= 1'b0;
      valid_out        <= 1'b0;
    end else begin
      div_start_reg <= 1'b0;
      valid_out     <= 1'b0;
      case (state_reg)
        ST_ACCUM: begin
          if (tabulate_in) begin
            n_snap   <= n_add;
            sx_snap  <= sx_add;
            sy_snap  <= sy_add;
            sxx_snap <= sxx_add;
            sxy_snap <= sxy_add;
            n_reg <= '0; sx_reg <= '0; sy_reg <= '0; sxx_reg <= '0; sxy_reg <= '0;
            x_work       <= '0;
            y_work       <= '0;
            mag_work     <= '0;
            sign_work    <= 1'b0;
            m_issued_reg <= 1'b0;
            if (n_add == '0) begin
              deg_work <= 1'b1;
            end else begin
              deg_work         <= 1'b0;
              div_start_reg    <= 1'b1;
              div_dividend_reg <= DIV_WIDTH'(sx_add);
              div_divisor_reg  <= DIV_WIDTH'(n_add);
            end
          end else begin
            n_reg   <= n_add;
            sx_reg  <= sx_add;
            sy_reg  <= sy_add;
            sxx_reg <= sxx_add;
            sxy_reg <= sxy_add;
          end
        end
        ST_DIV_X: begin
          if (div_valid) begin
            x_work           <= div_quotient[10:0];
            if (div_error) deg_work <= 1'b1;
            div_start_reg    <= 1'b1;
            div_dividend_reg <= DIV_WIDTH'(sy_snap);
            div_divisor_reg  <= DIV_WIDTH'(n_snap);
          end
        end
        ST_DIV_Y: begin
          if (div_valid) begin
            y_work <= div_quotient[9:0];
            if (div_error) deg_work <= 1'b1;
          end
        end
        ST_PRODUCTS: begin
          num_reg <= num_comb;
          den_reg <= den_comb;
        end
        ST_DIV_M: begin
          if (!m_issued_reg) begin
            if (den_reg == '0) begin
              // Vertical line: no divide, saturate as a positive slope
              mag_work  <= SLOPE_MAG_MAX;
              sign_work <= 1'b0;
              deg_work  <= 1'b1;
            end else begin
              m_issued_reg     <= 1'b1;
              div_start_reg    <= 1'b1;
              div_dividend_reg <= DIV_WIDTH'(num_mag) << SLOPE_FRAC_BITS;
              div_divisor_reg  <= DIV_WIDTH'(den_reg);
            end
          end else if (div_valid) begin
            sign_work <= num_reg[PROD_W-1];
            if (div_error) begin
              mag_work <= SLOPE_MAG_MAX;
              deg_work <= 1'b1;
            end else if (|div_quotient[DIV_WIDTH-1:24]) begin
              mag_work <= SLOPE_MAG_MAX;
            end else begin
              mag_work <= div_quotient[23:0];
            end
          end
        end
        ST_DONE: begin
          x_com          <= x_work;
          y_com          <= y_work;
          m_out          <= {sign_work, mag_work};
          degenerate_out <= deg_work;
          valid_out      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_FIT_INTERCEPT_EN
  logic signed [39:0] slope_s, prod_s, b_full;
  logic [17:0]        b_work;

  // b = y_com - (m * x_com) >>> 8 with the slope re-signed from sign-magnitude
  always_comb begin
    slope_s = $signed({16'd0, mag_work});
    if (sign_work) slope_s = -slope_s;
    prod_s  = slope_s * $signed({29'd0, x_work});
    b_full  = $signed({30'd0, y_work}) - (prod_s >>> SLOPE_FRAC_BITS);
  end

  // Intercept working register and its output copy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      b_work <= '0;
      b_out  <= '0;
    end else begin
      if (state_reg == ST_ACCUM && tabulate_in) b_work <= '0;
      if (state_reg == ST_INTERCEPT)            b_work <= sat_b(b_full);
      if (state_reg == ST_DONE)                 b_out  <= b_work;
    end
  end
`else
  assign b_out = '0;
`endif

endmodule
